sweep_scheduler: RTL and testbench



---
 rtl/sweep_scheduler_if.sv | 32 +++
 rtl/sweep_scheduler.sv | 167 ++++++++++++++++
 tb/tb_sweep_scheduler.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sweep_scheduler_if.sv
// Bundles the sweep configuration inputs, the DDS-loader req/ack handshake and the status outputs.
// With SWEEP_HOLD_EN defined the bundle also carries sweep_hold.
interface sweep_scheduler_if;
  logic [19:0] base_freq;
  logic [16:0] sweep_range;
  logic [12:0] sweep_speed;
  logic [1:0]  sweep_mode;
  logic [19:0] cur_freq;
  logic        upd_req;
  logic        upd_ack;
  logic        sweep_active;
  logic        sweep_dir;
`ifdef SWEEP_HOLD_EN
  logic        sweep_hold;
`endif

  modport master (
    input  base_freq, sweep_range, sweep_speed, sweep_mode, upd_ack,
`ifdef SWEEP_HOLD_EN
    input  sweep_hold,
`endif
    output cur_freq, upd_req, sweep_active, sweep_dir
  );

  modport slave (
    output base_freq, sweep_range, sweep_speed, sweep_mode, upd_ack,
`ifdef SWEEP_HOLD_EN
    output sweep_hold,
`endif
    input  cur_freq, upd_req, sweep_active, sweep_dir
  );
endinterface

// File: rtl/sweep_scheduler.sv
// Advances a sweep position once per ms and publishes it to the DDS loader over req/ack.
// Optional macro SWEEP_HOLD_EN adds sweep_hold, which freezes the ms counter and the position.
module sweep_scheduler #(
  parameter int MS_DIV   = 100000,
  parameter int FREQ_MIN = 1000,
  parameter int FREQ_MAX = 999999
) (
  input  logic                clk,
  input  logic                rst_n,
  sweep_scheduler_if.master   sif
);
  localparam int              CW       = $clog2(MS_DIV + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(MS_DIV - 1);
  localparam logic [19:0]     FMIN     = 20'(FREQ_MIN);
  localparam logic [19:0]     FMAX     = 20'(FREQ_MAX);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} state_t;

  state_t        state_q, state_d;
  logic [19:0]   pos_q, pos_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [19:0]   base_q;
  logic [16:0]   range_q;
  logic [1:0]    mode_q;
  logic [19:0]   cur_q;
  logic          req_q;

  logic          hold;
`ifdef SWEEP_HOLD_EN
  assign hold = sif.sweep_hold;
`else
  assign hold = 1'b0;
`endif

  logic [19:0] lo, hi;
  logic [20:0] hi_sum, up_sum, down_lim;
  logic [19:0] down_val;
  logic        restart, tick, ramp_ok;
  state_t      entry_state;
  logic [19:0] entry_pos;

  always_comb begin
    if (sif.base_freq < FMIN)      lo = FMIN;
    else if (sif.base_freq > FMAX) lo = FMAX;
    else                           lo = sif.base_freq;
  end

  assign hi_sum   = {1'b0, lo} + {4'b0, sif.sweep_range};
  assign hi       = (hi_sum > {1'b0, FMAX}) ? FMAX : hi_sum[19:0];
  assign up_sum   = {1'b0, pos_q} + {8'b0, sif.sweep_speed};
  // pos - speed <= lo is evaluated as pos <= lo + speed so nothing underflows
  assign down_lim = {1'b0, lo} + {8'b0, sif.sweep_speed};
  assign down_val = pos_q - {7'b0, sif.sweep_speed};

  assign restart = (sif.base_freq != base_q) || (sif.sweep_range != range_q) ||
                   (sif.sweep_mode != mode_q);
  assign tick    = !hold && (cnt_q == CNT_LAST);
  assign ramp_ok = (sif.sweep_mode != 2'b00) && (sif.sweep_range != '0) &&
                   (sif.sweep_speed != '0);

  always_comb begin
    entry_state = S_IDLE;
    if (ramp_ok) entry_state = (sif.sweep_mode == 2'b10) ? S_DOWN : S_UP;
    entry_pos = (entry_state == S_DOWN) ? hi : lo;
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    if (hold)      cnt_d = cnt_q;
    else if (tick) cnt_d = '0;
    else           cnt_d = cnt_q + 1'b1;

    // restart takes priority: a coincident tick is dropped
    if (restart) begin
      cnt_d   = '0;
      state_d = entry_state;
      pos_d   = entry_pos;
    end else begin
      case (state_q)
        S_IDLE: begin
          pos_d = lo;
          if (ramp_ok) begin
            state_d = entry_state;
            pos_d   = entry_pos;
          end
        end
        S_UP: begin
          if (!ramp_ok) begin
            state_d = S_IDLE;
            pos_d   = lo;
          end else if (tick) begin
            if (up_sum >= {1'b0, hi}) begin
              if (sif.sweep_mode == 2'b11) begin
                pos_d   = hi;
                state_d = S_DOWN;
              end else begin
                pos_d = lo;
              end
            end else begin
              pos_d = up_sum[19:0];
            end
          end
        end
        S_DOWN: begin
          if (!ramp_ok) begin
            state_d = S_IDLE;
            pos_d   = lo;
          end else if (tick) begin
            if ({1'b0, pos_q} <= down_lim) begin
              if (sif.sweep_mode == 2'b11) begin
                pos_d   = lo;
                state_d = S_UP;
              end else begin
                pos_d = hi;
              end
            end else begin
              pos_d = down_val;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          pos_d   = lo;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pos_q   <= FMIN;
      cnt_q   <= '0;
      base_q  <= '0;
      range_q <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      if (restart) begin
        base_q  <= sif.base_freq;
        range_q <= sif.sweep_range;
        mode_q  <= sif.sweep_mode;
      end
    end
  end

  // Only the latest pos is loaded once the loader frees the slot; skipped values are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= FMIN;
      req_q <= 1'b0;
    end else if (req_q) begin
      if (sif.upd_ack) req_q <= 1'b0;
    end else if (pos_q != cur_q) begin
      cur_q <= pos_q;
      req_q <= 1'b1;
    end
  end

  assign sif.cur_freq     = cur_q;
  assign sif.upd_req      = req_q;
  assign sif.sweep_active = (state_q != S_IDLE);
  assign sif.sweep_dir    = (state_q != S_DOWN);
endmodule

// File: tb/tb_sweep_scheduler.sv
// Directed bench for sweep_scheduler with a short ms divider; expected values are hand-computed.
module tb_sweep_scheduler;
  localparam int MS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  sweep_scheduler_if sif();

  sweep_scheduler #(.MS_DIV(MS), .FREQ_MIN(1000), .FREQ_MAX(999999)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * MS && !ok; i++) begin
      @(negedge clk);
      if (sif.upd_req) ok = 1'b1;
    end
  endtask

  // waits for a request, checks the published value and direction, then acks it
  task automatic pub(input string tag, input int f, input bit d, output int t);
    bit ok;
    wait_req(ok);
    t = cyc;
    chk({tag, "_req"}, 32'(ok), 32'd1);
    chk({tag, "_freq"}, 32'(sif.cur_freq), 32'(f));
    chk({tag, "_dir"}, 32'(sif.sweep_dir), 32'(d));
    sif.upd_ack = 1'b1;
    @(negedge clk);
    sif.upd_ack = 1'b0;
    chk({tag, "_clr"}, 32'(sif.upd_req), 32'd0);
  endtask

  task automatic cfg(input int b, input int r, input int s, input int m);
    sif.base_freq   = 20'(b);
    sif.sweep_range = 17'(r);
    sif.sweep_speed = 13'(s);
    sif.sweep_mode  = 2'(m);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sif.upd_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int t, tp;
  bit flag, ok;
  int saw[6]  = '{100000, 104000, 108000, 112000, 116000, 100000};
  int tri_f[5] = '{3000, 4000, 2000, 1000, 3000};
  bit tri_d[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  int dn_f[4]  = '{999999, 995999, 991999, 999999};

  initial begin
    sif.upd_ack = 1'b0;
`ifdef SWEEP_HOLD_EN
    sif.sweep_hold = 1'b0;
`endif
    // static mode
    cfg(100000, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_cur", 32'(sif.cur_freq), 32'd1000);
    chk("rst_req", 32'(sif.upd_req), 32'd0);
    chk("rst_act", 32'(sif.sweep_active), 32'd0);
    chk("rst_dir", 32'(sif.sweep_dir), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("st_req1", 32'(sif.upd_req), 32'd0);
    @(negedge clk);
    chk("st_req2", 32'(sif.upd_req), 32'd1);
    chk("st_cur2", 32'(sif.cur_freq), 32'd100000);
    sif.upd_ack = 1'b1;
    @(negedge clk);
    sif.upd_ack = 1'b0;
    chk("st_clr", 32'(sif.upd_req), 32'd0);
    flag = 1'b0;
    repeat (3 * MS) begin
      @(negedge clk);
      if (sif.upd_req) flag = 1'b1;
    end
    chk("st_noreq", 32'(flag), 32'd0);
    sif.upd_ack = 1'b1;
    @(negedge clk);
    sif.upd_ack = 1'b0;
    @(negedge clk);
    chk("st_ack_ign", 32'(sif.upd_req), 32'd0);
    chk("st_cur_hold", 32'(sif.cur_freq), 32'd100000);

    // sawtooth up, one publish per ms
    cfg(100000, 20000, 4000, 1);
    do_reset();
    tp = 0;
    foreach (saw[i]) begin
      pub($sformatf("saw%0d", i), saw[i], 1'b1, t);
      if (i > 0) chk($sformatf("saw_ival%0d", i), 32'(t - tp), 32'(MS));
      tp = t;
    end
    chk("saw_act", 32'(sif.sweep_active), 32'd1);

    // triangle
    cfg(1000, 3000, 2000, 3);
    do_reset();
    repeat (2) @(negedge clk);
    chk("tri_cur0", 32'(sif.cur_freq), 32'd1000);
    chk("tri_req0", 32'(sif.upd_req), 32'd0);
    chk("tri_act0", 32'(sif.sweep_active), 32'd1);
    chk("tri_dir0", 32'(sif.sweep_dir), 32'd1);
    foreach (tri_f[i]) pub($sformatf("tri%0d", i), tri_f[i], tri_d[i], t);

    // sawtooth down with hi clamped at FREQ_MAX
    cfg(990000, 20000, 4000, 2);
    do_reset();
    foreach (dn_f[i]) pub($sformatf("dn%0d", i), dn_f[i], 1'b0, t);
    chk("dn_act", 32'(sif.sweep_active), 32'd1);

    // stalled loader: intermediates coalesce
    cfg(200000, 20000, 1000, 1);
    do_reset();
    pub("hold0", 200000, 1'b1, t);
    wait_req(ok);
    chk("hold_req", 32'(ok), 32'd1);
    chk("hold_cur", 32'(sif.cur_freq), 32'd201000);
    flag = 1'b0;
    repeat (MS * 7 / 2) begin
      @(negedge clk);
      if (!sif.upd_req || sif.cur_freq != 20'd201000) flag = 1'b1;
    end
    chk("hold_stable", 32'(flag), 32'd0);
    sif.upd_ack = 1'b1;
    @(negedge clk);
    sif.upd_ack = 1'b0;
    chk("hold_clr", 32'(sif.upd_req), 32'd0);
    pub("hold_next", 204000, 1'b1, t);
    // speed to zero drops to idle at base
    sif.sweep_speed = '0;
    @(negedge clk);
    chk("spd0_act", 32'(sif.sweep_active), 32'd0);
    pub("spd0", 200000, 1'b1, t);

    // base change on the tick edge
    cfg(100000, 20000, 4000, 1);
    do_reset();
    pub("rs0", 100000, 1'b1, t);
    pub("rs1", 104000, 1'b1, t);
    repeat (MS - 3) @(negedge clk);
    sif.base_freq = 20'd150000;
    @(negedge clk);
    @(negedge clk);
    tp = cyc;
    chk("rs_req", 32'(sif.upd_req), 32'd1);
    chk("rs_cur", 32'(sif.cur_freq), 32'd150000);
    sif.upd_ack = 1'b1;
    @(negedge clk);
    sif.upd_ack = 1'b0;
    pub("rs2", 154000, 1'b1, t);
    chk("rs_ival", 32'(t - tp), 32'(MS));

    // asynchronous reset while a request is outstanding
    wait_req(ok);
    chk("ar_req", 32'(ok), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req0", 32'(sif.upd_req), 32'd0);
    chk("ar_cur", 32'(sif.cur_freq), 32'd1000);
    chk("ar_act", 32'(sif.sweep_active), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
